// File: rtl/ps2_kbd_rx_pkg.sv
// Shared constants for the PS/2 keyboard receiver: FSM encodings and frame geometry.
package ps2_kbd_rx_pkg;

    localparam int unsigned FRAME_DATA_BITS = 8;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StData   = 2'd1;
    localparam logic [1:0] StParity = 2'd2;
    localparam logic [1:0] StStop   = 2'd3;

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Push/notfull handshake between the PS/2 receiver and the scan-code FIFO.
interface ps2_kbd_rx_if;
    import ps2_kbd_rx_pkg::*;

    logic                       push;
    logic                       notfull;
    logic [FRAME_DATA_BITS-1:0] outData;

    modport master (output push, output outData, input notfull);
    modport slave  (input push, input outData, output notfull);
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser for ps2Clk/ps2Data, majority-free run-length filter on the
// clock and falling-edge detect of the filtered clock.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic fall_o,
    output logic data_o
);

    logic [1:0]            clk_sync_q, clk_sync_d;
    logic [1:0]            data_sync_q, data_sync_d;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  filt_clk_q, filt_clk_d;

    // Next-state: shift synchronisers and filter, filtered clock only moves on a full run.
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk_i};
        data_sync_d = {data_sync_q[0], ps2_data_i};
        filt_d      = {filt_q[FILTER_LEN-2:0], clk_sync_q[1]};
        filt_clk_d  = filt_clk_q;
        if (&filt_d) begin
            filt_clk_d = 1'b1;
        end else if (~|filt_d) begin
            filt_clk_d = 1'b0;
        end
        fall_o = filt_clk_q & ~filt_clk_d;
        data_o = data_sync_q[1];
    end

    // State registers; idle-high bus so everything resets to 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            filt_q      <= '1;
            filt_clk_q  <= 1'b1;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_q      <= filt_d;
            filt_clk_q  <= filt_clk_d;
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: deserialises device-to-host frames, holds one byte and
// pushes it to the scan-code FIFO; reports errors as one-cycle pulses.
module ps2_kbd_rx
    import ps2_kbd_rx_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ps2Clk,
    input  logic                ps2Data,
    ps2_kbd_rx_if.master        fifo,
    output logic                parityErr,
    output logic                frameErr,
    output logic                overflow
);

    // Timeout fires when the count would reach TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] TmoLast = CNT_W'(TIMEOUT_CYCLES - 1);

    logic fall, data;

    logic [1:0]                 state_q, state_d;
    logic [2:0]                 bit_cnt_q, bit_cnt_d;
    logic [FRAME_DATA_BITS-1:0] shreg_q, shreg_d;
    logic                       parity_q, parity_d;
    logic [CNT_W-1:0]           tmo_q, tmo_d;
    logic                       valid_q, valid_d;
    logic [FRAME_DATA_BITS-1:0] out_data_q, out_data_d;
    logic                       parity_err_q, parity_err_d;
    logic                       frame_err_q, frame_err_d;
    logic                       overflow_q, overflow_d;
    logic                       byte_ok, push;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk_i  (ps2Clk),
        .ps2_data_i (ps2Data),
        .fall_o     (fall),
        .data_o     (data)
    );

    // Frame FSM, timeout counter and holding-register next-state.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        parity_d     = parity_q;
        valid_d      = valid_q;
        out_data_d   = out_data_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        overflow_d   = 1'b0;
        byte_ok      = 1'b0;
        push         = valid_q & fifo.notfull;

        if (state_q == StIdle || fall) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        if (fall) begin
            unique case (state_q)
                StIdle: begin
                    if (!data) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                StData: begin
                    shreg_d = {data, shreg_q[FRAME_DATA_BITS-1:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                StParity: begin
                    parity_d = data;
                    state_d  = StStop;
                end
                StStop: begin
                    if (!data) begin
                        frame_err_d = 1'b1;
                    end else if (!(^{shreg_q, parity_q})) begin
                        parity_err_d = 1'b1;
                    end else begin
                        byte_ok = 1'b1;
                    end
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle && tmo_q == TmoLast) begin
            state_d     = StIdle;
            frame_err_d = 1'b1;
            tmo_d       = '0;
        end

        // A same-cycle push frees the slot, so the new byte loads instead of overflowing.
        if (byte_ok && (!valid_q || push)) begin
            valid_d    = 1'b1;
            out_data_d = shreg_q;
        end else begin
            if (byte_ok) begin
                overflow_d = 1'b1;
            end
            if (push) begin
                valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            valid_q      <= 1'b0;
            out_data_q   <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            parity_q     <= parity_d;
            tmo_q        <= tmo_d;
            valid_q      <= valid_d;
            out_data_q   <= out_data_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
        end
    end

    assign fifo.push    = push;
    assign fifo.outData = out_data_q;
    assign parityErr    = parity_err_q;
    assign frameErr     = frame_err_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: table of single frames plus hand-written corner sequences.
module tb_ps2_kbd_rx;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ps2Clk = 1'b1;
    logic ps2Data = 1'b1;
    logic parityErr, frameErr, overflow;

    ps2_kbd_rx_if fifo_if ();

    ps2_kbd_rx dut (
        .clk       (clk),
        .reset     (reset),
        .ps2Clk    (ps2Clk),
        .ps2Data   (ps2Data),
        .fifo      (fifo_if.master),
        .parityErr (parityErr),
        .frameErr  (frameErr),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Monitor: counts strobes and records pushed bytes.
    int push_cnt = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    int ovf_cnt = 0;
    logic [7:0] pushed[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (fifo_if.push) begin
                push_cnt = push_cnt + 1;
                pushed.push_back(fifo_if.outData);
            end
            if (parityErr) perr_cnt = perr_cnt + 1;
            if (frameErr) ferr_cnt = ferr_cnt + 1;
            if (overflow) ovf_cnt = ovf_cnt + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2Data = b;
        tick(10);
        ps2Clk = 1'b0;
        tick(20);
        ps2Clk = 1'b1;
        tick(10);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stp);
        ps2Data = 1'b1;
        tick(30);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stp;
        int         exp_push;
        logic [7:0] exp_byte;
        int         exp_perr;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    int b_push, b_perr, b_ferr, b_ovf, b_q;

    task automatic snap();
        b_push = push_cnt;
        b_perr = perr_cnt;
        b_ferr = ferr_cnt;
        b_ovf  = ovf_cnt;
        b_q    = pushed.size();
    endtask

    initial begin
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 8'h1C, 0, 0};
        vecs[1] = '{8'hF0, 1'b1, 1'b1, 1, 8'hF0, 0, 0};
        vecs[2] = '{8'h1C, 1'b1, 1'b1, 0, 8'h00, 1, 0};
        vecs[3] = '{8'h5A, 1'b1, 1'b1, 1, 8'h5A, 0, 0};
        vecs[4] = '{8'h1C, 1'b0, 1'b0, 0, 8'h00, 0, 1};
        vecs[5] = '{8'h34, 1'b0, 1'b1, 1, 8'h34, 0, 0};

        fifo_if.notfull = 1'b1;
        tick(4);
        @(negedge clk);
        check("reset_push", int'(fifo_if.push), 0);
        check("reset_outdata", int'(fifo_if.outData), 0);
        check("reset_errs", int'({parityErr, frameErr, overflow}), 0);
        reset = 1'b0;
        tick(20);

        // Table-driven single frames.
        for (int v = 0; v < 6; v++) begin
            snap();
            send_frame(vecs[v].data, vecs[v].par, vecs[v].stp);
            check($sformatf("v%0d_push", v), push_cnt - b_push, vecs[v].exp_push);
            if (vecs[v].exp_push == 1 && pushed.size() > b_q)
                check($sformatf("v%0d_byte", v), int'(pushed[b_q]), int'(vecs[v].exp_byte));
            check($sformatf("v%0d_perr", v), perr_cnt - b_perr, vecs[v].exp_perr);
            check($sformatf("v%0d_ferr", v), ferr_cnt - b_ferr, vecs[v].exp_ferr);
            check($sformatf("v%0d_ovf", v), ovf_cnt - b_ovf, 0);
        end

        // Back-to-back frames keep order.
        snap();
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("b2b_count", pushed.size() - b_q, 2);
        if (pushed.size() >= b_q + 2) begin
            check("b2b_first", int'(pushed[b_q]), 'hF0);
            check("b2b_second", int'(pushed[b_q+1]), 'h1C);
        end

        // Overflow with FIFO full: second byte dropped, first held.
        snap();
        fifo_if.notfull = 1'b0;
        send_frame(8'h12, 1'b1, 1'b1);
        send_frame(8'h34, 1'b0, 1'b1);
        check("ovf_pulse", ovf_cnt - b_ovf, 1);
        check("ovf_nopush", push_cnt - b_push, 0);
        check("ovf_hold", int'(fifo_if.outData), 'h12);
        fifo_if.notfull = 1'b1;
        tick(10);
        check("ovf_drain_cnt", push_cnt - b_push, 1);
        if (pushed.size() > b_q) check("ovf_drain_byte", int'(pushed[b_q]), 'h12);

        // Timeout after start + 4 data bits.
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2Data = 1'b1;
        tick(3500);
        check("tmo_early", ferr_cnt - b_ferr, 0);
        tick(800);
        check("tmo_ferr", ferr_cnt - b_ferr, 1);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("tmo_next_push", push_cnt - b_push, 1);
        if (pushed.size() > b_q) check("tmo_next_byte", int'(pushed[b_q]), 'h1C);

        // Held byte then mid-frame reset, glitches, clean frame.
        snap();
        fifo_if.notfull = 1'b0;
        send_frame(8'h5A, 1'b1, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        fifo_if.notfull = 1'b1;
        ps2Data = 1'b1;
        tick(10);
        for (int g = 0; g < 5; g++) begin
            ps2Clk = 1'b0;
            tick(3);
            ps2Clk = 1'b1;
            tick(15);
        end
        tick(5000);
        check("rst_nopush", push_cnt - b_push, 0);
        check("glitch_noerr", (ferr_cnt - b_ferr) + (perr_cnt - b_perr), 0);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("rst_clean_push", push_cnt - b_push, 1);
        if (pushed.size() > b_q) check("rst_clean_byte", int'(pushed[b_q]), 'h1C);
        check("rst_clean_noerr", (ferr_cnt - b_ferr) + (perr_cnt - b_perr) + (ovf_cnt - b_ovf), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
